// File: rtl/ysyx_040066_mem_arbiter.sv
// N-master memory arbiter: merges upstream masters onto one downstream read
// channel and one downstream write channel. Request fields are latched at
// grant. Arbitration is fixed priority or round-robin, and responses are
// routed only to the granted master.
module ysyx_040066_mem_arbiter #(
   parameter int NUM_MASTERS = 2,
   parameter int ADDR_W      = 64,
   parameter int DATA_W      = 64,
   parameter int LINE_W      = 512,
   parameter int RR_MODE     = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_MASTERS-1:0]        m_req,
   input  logic [NUM_MASTERS-1:0]        m_we,
   input  logic [NUM_MASTERS-1:0]        m_burst,
   input  logic [3*NUM_MASTERS-1:0]      m_len,
   input  logic [ADDR_W*NUM_MASTERS-1:0] m_addr,
   input  logic [8*NUM_MASTERS-1:0]      m_wmask,
   input  logic [LINE_W*NUM_MASTERS-1:0] m_wdata,
   output logic [NUM_MASTERS-1:0]        m_ready,
   output logic [NUM_MASTERS-1:0]        m_err,
   output logic [NUM_MASTERS-1:0]        m_last,
   output logic [DATA_W-1:0]             m_rdata,
   output logic                          rd_req,
   output logic                          rd_burst,
   output logic [2:0]                    rd_len,
   output logic [ADDR_W-1:0]             rd_addr,
   input  logic                          rd_ready,
   input  logic                          rd_err,
   input  logic                          rd_last,
   input  logic [DATA_W-1:0]             rd_data,
   output logic                          wr_req,
   output logic                          wr_burst,
   output logic [2:0]                    wr_len,
   output logic [7:0]                    wr_mask,
   output logic [ADDR_W-1:0]             wr_addr,
   output logic [LINE_W-1:0]             wr_data,
   input  logic                          wr_ready,
   input  logic                          wr_err,
   output logic                          busy,
   output logic [NUM_MASTERS-1:0]        grant
);

   localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

   state_t                   state, state_d;
   logic [GW-1:0]            rr_ptr, rr_next;
   logic [NUM_MASTERS-1:0]   holdoff, eligible, g_onehot;
   logic [GW-1:0]            g_q, win_idx;
   logic [GW:0]              sum;
   logic                     burst_q;
   logic [2:0]               len_q;
   logic [ADDR_W-1:0]        addr_q;
   logic [7:0]               wmask_q;
   logic [LINE_W-1:0]        wdata_q;
   logic                     w_we, w_burst;
   logic [2:0]               w_len;
   logic [ADDR_W-1:0]        w_addr;
   logic [7:0]               w_wmask;
   logic [LINE_W-1:0]        w_wdata;
   logic                     done;

   // The master that just finished sits out exactly one IDLE cycle.
   assign eligible = m_req & ~holdoff;

   // Read data is broadcast; masters qualify it with their own m_ready.
   assign m_rdata = rd_data;

   // Pick the winning master index among the eligible requests.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      win_idx = '0;
      sum     = '0;
      if (RR_MODE == 0) begin
         // Scan downwards so the lowest eligible index is written last.
         for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (eligible[i]) win_idx = GW'(i);
         end
      end else begin
         // Scan offsets from rr_ptr downwards so the nearest one wins.
         for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr} + (GW+1)'(k);
            if (sum >= (GW+1)'(NUM_MASTERS)) sum = sum - (GW+1)'(NUM_MASTERS);
            if (eligible[sum[GW-1:0]]) win_idx = sum[GW-1:0];
         end
      end
   end

   // Extract the winning master's request fields from the packed buses.
   always_comb begin
      w_we    = 1'b0;
      w_burst = 1'b0;
      w_len   = '0;
      w_addr  = '0;
      w_wmask = '0;
      w_wdata = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (win_idx == GW'(i)) begin
            w_we    = m_we[i];
            w_burst = m_burst[i];
            w_len   = m_len[3*i +: 3];
            w_addr  = m_addr[ADDR_W*i +: ADDR_W];
            w_wmask = m_wmask[8*i +: 8];
            w_wdata = m_wdata[LINE_W*i +: LINE_W];
         end
      end
   end

   // Decode the granted index to one-hot and compute the next rr pointer.
   always_comb begin
      g_onehot = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         g_onehot[i] = (g_q == GW'(i));
      end
      rr_next = (g_q == GW'(NUM_MASTERS - 1)) ? '0 : g_q + 1'b1;
   end

   // Next-state logic and all downstream/upstream outputs.
   always_comb begin
      state_d  = state;
      done     = 1'b0;
      busy     = (state != IDLE);
      grant    = '0;
      m_ready  = '0;
      m_err    = '0;
      m_last   = '0;
      rd_req   = 1'b0;
      rd_burst = 1'b0;
      rd_len   = '0;
      rd_addr  = '0;
      wr_req   = 1'b0;
      wr_burst = 1'b0;
      wr_len   = '0;
      wr_mask  = '0;
      wr_addr  = '0;
      wr_data  = '0;
      case (state)
         IDLE: begin
            if (|eligible) state_d = w_we ? WRITE : READ;
         end
         READ: begin
            grant    = g_onehot;
            rd_req   = 1'b1;
            rd_burst = burst_q;
            rd_len   = len_q;
            rd_addr  = addr_q;
            m_ready  = g_onehot & {NUM_MASTERS{rd_ready}};
            m_err    = g_onehot & {NUM_MASTERS{rd_err}};
            m_last   = g_onehot & {NUM_MASTERS{rd_last}};
            if (rd_err || (rd_ready && (rd_last || !burst_q))) begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
         WRITE: begin
            grant    = g_onehot;
            wr_req   = 1'b1;
            wr_burst = burst_q;
            wr_len   = len_q;
            wr_mask  = wmask_q;
            wr_addr  = addr_q;
            wr_data  = wdata_q;
            m_ready  = g_onehot & {NUM_MASTERS{wr_ready}};
            m_err    = g_onehot & {NUM_MASTERS{wr_err}};
            if (wr_ready || wr_err) begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register, grant latch, holdoff mask and round-robin pointer.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         // NOTE: the latched line is an ordinary register (not a memory
         // array), so it is cleared with everything else and idle outputs
         // never expose stale data.
         state   <= IDLE;
         rr_ptr  <= '0;
         holdoff <= '0;
         g_q     <= '0;
         burst_q <= 1'b0;
         len_q   <= '0;
         addr_q  <= '0;
         wmask_q <= '0;
         wdata_q <= '0;
      end else begin
         state <= state_d;
         if (state == IDLE) begin
            holdoff <= '0;
            if (|eligible) begin
               g_q     <= win_idx;
               burst_q <= w_burst;
               len_q   <= w_len;
               addr_q  <= w_addr;
               wmask_q <= w_wmask;
               wdata_q <= w_wdata;
            end
         end else if (done) begin
            holdoff <= g_onehot;
            if (RR_MODE != 0) rr_ptr <= rr_next;
         end
      end
   end

endmodule

// File: tb/tb_ysyx_040066_mem_arbiter.sv
// Directed bench for the memory arbiter: a fixed-priority and a round-robin
// instance share all inputs; responses to the fixed-priority instance are
// scoreboarded, grant order is checked on both.
module tb_ysyx_040066_mem_arbiter;

   typedef struct packed {
      logic [1:0]  ready;
      logic [1:0]  err;
      logic [1:0]  last;
      logic [63:0] data;
   } rsp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    m_req, m_we, m_burst;
   logic [5:0]    m_len;
   logic [127:0]  m_addr;
   logic [15:0]   m_wmask;
   logic [1023:0] m_wdata;
   logic          rd_ready, rd_err, rd_last, wr_ready, wr_err;
   logic [63:0]   rd_data;

   logic [1:0]   fp_m_ready, fp_m_err, fp_m_last, fp_grant;
   logic [63:0]  fp_m_rdata, fp_rd_addr, fp_wr_addr;
   logic         fp_rd_req, fp_rd_burst, fp_wr_req, fp_wr_burst, fp_busy;
   logic [2:0]   fp_rd_len, fp_wr_len;
   logic [7:0]   fp_wr_mask;
   logic [511:0] fp_wr_data;

   logic [1:0]   rr_m_ready, rr_m_err, rr_m_last, rr_grant;
   logic [63:0]  rr_m_rdata, rr_rd_addr, rr_wr_addr;
   logic         rr_rd_req, rr_rd_burst, rr_wr_req, rr_wr_burst, rr_busy;
   logic [2:0]   rr_rd_len, rr_wr_len;
   logic [7:0]   rr_wr_mask;
   logic [511:0] rr_wr_data;

   int   n_assert = 0;
   int   n_fail   = 0;
   rsp_t sb[$];
   int   fp_q[$];
   int   rr_q[$];

   always #5 clk = ~clk;

   ysyx_040066_mem_arbiter #(.NUM_MASTERS(2), .RR_MODE(0)) fp (
      .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_burst(m_burst),
      .m_len(m_len), .m_addr(m_addr), .m_wmask(m_wmask), .m_wdata(m_wdata),
      .m_ready(fp_m_ready), .m_err(fp_m_err), .m_last(fp_m_last), .m_rdata(fp_m_rdata),
      .rd_req(fp_rd_req), .rd_burst(fp_rd_burst), .rd_len(fp_rd_len), .rd_addr(fp_rd_addr),
      .rd_ready(rd_ready), .rd_err(rd_err), .rd_last(rd_last), .rd_data(rd_data),
      .wr_req(fp_wr_req), .wr_burst(fp_wr_burst), .wr_len(fp_wr_len), .wr_mask(fp_wr_mask),
      .wr_addr(fp_wr_addr), .wr_data(fp_wr_data), .wr_ready(wr_ready), .wr_err(wr_err),
      .busy(fp_busy), .grant(fp_grant)
   );

   ysyx_040066_mem_arbiter #(.NUM_MASTERS(2), .RR_MODE(1)) rr (
      .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_burst(m_burst),
      .m_len(m_len), .m_addr(m_addr), .m_wmask(m_wmask), .m_wdata(m_wdata),
      .m_ready(rr_m_ready), .m_err(rr_m_err), .m_last(rr_m_last), .m_rdata(rr_m_rdata),
      .rd_req(rr_rd_req), .rd_burst(rr_rd_burst), .rd_len(rr_rd_len), .rd_addr(rr_rd_addr),
      .rd_ready(rd_ready), .rd_err(rd_err), .rd_last(rd_last), .rd_data(rd_data),
      .wr_req(rr_wr_req), .wr_burst(rr_wr_burst), .wr_len(rr_wr_len), .wr_mask(rr_wr_mask),
      .wr_addr(rr_wr_addr), .wr_data(rr_wr_data), .wr_ready(wr_ready), .wr_err(wr_err),
      .busy(rr_busy), .grant(rr_grant)
   );

   function automatic logic [1:0] oh(input int i);
      return 2'b01 << i;
   endfunction

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Move to just after the next rising edge, where inputs are driven.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Sample on the falling edge; pop one expected response or expect silence.
   task automatic observe(input string tag);
      rsp_t e;
      @(negedge clk);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check({tag, "_ready"}, fp_m_ready, e.ready);
         check({tag, "_err"},   fp_m_err,   e.err);
         check({tag, "_last"},  fp_m_last,  e.last);
         check({tag, "_rdata"}, fp_m_rdata, e.data);
      end else begin
         check({tag, "_no_ready"}, fp_m_ready, 2'b00);
         check({tag, "_no_err"},   fp_m_err,   2'b00);
      end
   endtask

   // Drive one downstream read beat and queue the expected upstream strobe.
   task automatic read_beat(input logic [63:0] d, input logic last, input logic [1:0] who);
      rd_ready = 1'b1;
      rd_data  = d;
      rd_last  = last;
      sb.push_back('{ready: who, err: 2'b00, last: (last ? who : 2'b00), data: d});
   endtask

   task automatic grant_chk(input string tag);
      int e;
      e = fp_q.pop_front();
      check({tag, "_fp_grant"}, fp_grant, oh(e));
      e = rr_q.pop_front();
      check({tag, "_rr_grant"}, rr_grant, oh(e));
   endtask

   task automatic set_rd(input int i, input logic burst, input logic [2:0] len, input logic [63:0] a);
      m_req[i]          = 1'b1;
      m_we[i]           = 1'b0;
      m_burst[i]        = burst;
      m_len[3*i +: 3]   = len;
      m_addr[64*i +: 64] = a;
   endtask

   task automatic end_rsp();
      rd_ready = 1'b0;
      rd_last  = 1'b0;
      rd_err   = 1'b0;
      wr_ready = 1'b0;
      wr_err   = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      m_req = '0; m_we = '0; m_burst = '0; m_len = '0;
      m_addr = '0; m_wmask = '0; m_wdata = '0;
      rd_data = '0;
      end_rsp();
      step();
      step();

      // Reset state.
      @(negedge clk);
      check("rst_busy",    fp_busy,    1'b0);
      check("rst_grant",   fp_grant,   2'b00);
      check("rst_rd_req",  fp_rd_req,  1'b0);
      check("rst_wr_req",  fp_wr_req,  1'b0);
      check("rst_m_ready", fp_m_ready, 2'b00);
      check("rst_wr_data", fp_wr_data, 512'd0);
      check("rst_rr_busy", rr_busy,    1'b0);
      step();
      rst = 1'b0;

      // Test 1: master 0, 8-beat burst read.
      step();
      set_rd(0, 1'b1, 3'd7, 64'h8000_0040);
      observe("t1_req_cycle");
      check("t1_latency_rd_req", fp_rd_req, 1'b0);
      for (int b = 0; b < 8; b++) begin
         step();
         read_beat(64'hC0DE_0000_0000_0000 | 64'(b), (b == 7), 2'b01);
         observe("t1_beat");
         if (b == 0) begin
            check("t1_rd_req",   fp_rd_req,   1'b1);
            check("t1_rd_addr",  fp_rd_addr,  64'h8000_0040);
            check("t1_rd_len",   fp_rd_len,   3'd7);
            check("t1_rd_burst", fp_rd_burst, 1'b1);
            check("t1_grant",    fp_grant,    2'b01);
            check("t1_busy",     fp_busy,     1'b1);
         end
      end
      step();
      end_rsp();
      m_req = '0;
      observe("t1_after");
      check("t1_idle_busy",   fp_busy,   1'b0);
      check("t1_idle_rd_req", fp_rd_req, 1'b0);
      check("t1_sb_drained",  sb.size(), 0);

      // Test 2: simultaneous reads; master 0 drops its request one cycle late.
      step();
      set_rd(0, 1'b0, 3'd0, 64'h100);
      set_rd(1, 1'b0, 3'd0, 64'h200);
      fp_q.push_back(0); fp_q.push_back(1);
      rr_q.push_back(1); rr_q.push_back(0);
      observe("t2_req_cycle");
      step();
      read_beat(64'h1111, 1'b0, 2'b01);
      observe("t2_first");
      grant_chk("t2_first");
      check("t2_first_addr", fp_rd_addr, 64'h100);
      step();
      end_rsp();
      observe("t2_bubble");
      check("t2_bubble_busy", fp_busy, 1'b0);
      step();
      m_req[0] = 1'b0;
      read_beat(64'h2222, 1'b0, 2'b10);
      observe("t2_second");
      grant_chk("t2_second");
      check("t2_second_addr", fp_rd_addr, 64'h200);
      step();
      end_rsp();
      m_req = '0;
      observe("t2_bubble2");
      step();
      observe("t2_quiet");
      check("t2_no_regrant_fp", fp_busy, 1'b0);
      check("t2_no_regrant_rr", rr_busy, 1'b0);

      // Test 4: master 1 write answered with wr_err.
      step();
      m_req[1]          = 1'b1;
      m_we[1]           = 1'b1;
      m_burst[1]        = 1'b0;
      m_len[5:3]        = 3'd0;
      m_addr[127:64]    = 64'h2000_0100;
      m_wmask[15:8]     = 8'hFF;
      m_wdata[1023:512] = {64{8'hA5}};
      rd_data           = 64'h0;
      observe("t4_req_cycle");
      step();
      wr_err = 1'b1;
      sb.push_back('{ready: 2'b00, err: 2'b10, last: 2'b00, data: 64'h0});
      observe("t4_err");
      check("t4_wr_req",  fp_wr_req,  1'b1);
      check("t4_rd_req",  fp_rd_req,  1'b0);
      check("t4_wr_mask", fp_wr_mask, 8'hFF);
      check("t4_wr_data", fp_wr_data, {64{8'hA5}});
      check("t4_wr_addr", fp_wr_addr, 64'h2000_0100);
      check("t4_grant",   fp_grant,   2'b10);
      step();
      end_rsp();
      m_req = '0;
      m_we  = '0;
      observe("t4_after");
      check("t4_wr_req_drop", fp_wr_req, 1'b0);
      check("t4_busy",        fp_busy,   1'b0);

      // Test 3: both masters request continuously for four transactions.
      step();
      set_rd(0, 1'b0, 3'd0, 64'h300);
      set_rd(1, 1'b0, 3'd0, 64'h400);
      for (int t = 0; t < 4; t++) begin
         fp_q.push_back(t % 2);
         rr_q.push_back(t % 2);
      end
      observe("t3_req_cycle");
      for (int t = 0; t < 4; t++) begin
         step();
         read_beat(64'h3000 + 64'(t), 1'b0, oh(t % 2));
         observe("t3_beat");
         grant_chk("t3_order");
         step();
         end_rsp();
         if (t == 3) m_req[0] = 1'b0;
         observe("t3_bubble");
         check("t3_bubble_fp", fp_busy, 1'b0);
         check("t3_bubble_rr", rr_busy, 1'b0);
      end
      // Master 1 is still requesting in the bubble but is held off.
      step();
      m_req = '0;
      observe("t3_late_drop");
      check("t3_late_fp", fp_busy, 1'b0);
      check("t3_late_rr", rr_busy, 1'b0);
      // Serve master 0 alone, then let both compete: rr now favours master 1.
      step();
      set_rd(0, 1'b0, 3'd0, 64'h500);
      fp_q.push_back(0);
      rr_q.push_back(0);
      observe("t3_solo_req");
      step();
      read_beat(64'h5555, 1'b0, 2'b01);
      observe("t3_solo");
      grant_chk("t3_solo");
      step();
      end_rsp();
      m_req = '0;
      observe("t3_solo_bubble");
      step();
      set_rd(0, 1'b0, 3'd0, 64'h600);
      set_rd(1, 1'b0, 3'd0, 64'h700);
      fp_q.push_back(0);
      rr_q.push_back(1);
      observe("t3_pair_req");
      step();
      read_beat(64'h6666, 1'b0, 2'b01);
      observe("t3_pair");
      grant_chk("t3_pair");
      check("t3_pair_rr_addr", rr_rd_addr, 64'h700);
      step();
      end_rsp();
      m_req = '0;
      observe("t3_pair_bubble");

      // Test 5: stray responses are ignored, then a single non-burst read.
      step();
      rd_ready = 1'b1;
      rd_last  = 1'b1;
      wr_ready = 1'b1;
      rd_data  = 64'hDEAD;
      observe("t5_idle_stray");
      check("t5_idle_busy", fp_busy, 1'b0);
      step();
      end_rsp();
      set_rd(0, 1'b0, 3'd0, 64'h1000_0000);
      observe("t5_req_cycle");
      step();
      wr_ready = 1'b1;
      observe("t5_wrong_channel");
      check("t5_still_busy", fp_busy,     1'b1);
      check("t5_rd_burst",   fp_rd_burst, 1'b0);
      check("t5_rd_addr",    fp_rd_addr,  64'h1000_0000);
      step();
      end_rsp();
      read_beat(64'h5A5A, 1'b0, 2'b01);
      observe("t5_beat");
      step();
      end_rsp();
      m_req = '0;
      observe("t5_after");
      check("t5_busy", fp_busy, 1'b0);

      // Test 6: reset during beat 3 of an 8-beat read.
      step();
      set_rd(0, 1'b1, 3'd7, 64'h8000_0100);
      observe("t6_req_cycle");
      for (int b = 0; b < 2; b++) begin
         step();
         read_beat(64'h6000 + 64'(b), 1'b0, 2'b01);
         observe("t6_beat");
      end
      step();
      rd_ready = 1'b1;
      rd_data  = 64'h6002;
      rst      = 1'b1;
      step();
      rst = 1'b0;
      end_rsp();
      m_req = '0;
      observe("t6_after_rst");
      check("t6_busy",      fp_busy,   1'b0);
      check("t6_grant",     fp_grant,  2'b00);
      check("t6_rd_req",    fp_rd_req, 1'b0);
      check("t6_rd_addr",   fp_rd_addr, 64'h0);
      check("t6_rr_busy",   rr_busy,   1'b0);
      check("t6_rr_ptr",    rr.rr_ptr, 1'b0);
      step();
      set_rd(1, 1'b0, 3'd0, 64'h300);
      observe("t6_new_req");
      step();
      read_beat(64'h7777, 1'b0, 2'b10);
      observe("t6_new_beat");
      check("t6_new_grant", fp_grant,   2'b10);
      check("t6_new_addr",  fp_rd_addr, 64'h300);
      step();
      end_rsp();
      m_req = '0;
      observe("t6_new_after");
      check("t6_new_busy",  fp_busy,   1'b0);
      check("sb_empty_end", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
